// File: rtl/mskaes_serial_wrapper.sv
// mskaes_serial_wrapper: serial beat loader/unloader around a masked AES core using the shbus layout
module mskaes_serial_wrapper #(
  parameter int d = 2,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W*d-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W*d-1:0]   out_data,
  output logic             out_last,
  output logic             busy,
  output logic             core_valid_in,
  input  logic             core_ready,
  input  logic             core_cipher_valid,
  output logic [128*d-1:0] core_plaintext,
  output logic [128*d-1:0] core_key,
  input  logic [128*d-1:0] core_ciphertext
);
  localparam int NW = 128 / W;
  localparam int KW = $clog2(2 * NW);
  localparam int MW = NW > 1 ? $clog2(NW) : 1;
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [MW-1:0]    m_q, m_d;
  logic [128*d-1:0] pt_q, pt_d, key_q, key_d, buf_q, buf_d;
  logic             ld, acc, k_last, m_last;

  assign ld            = state_q == LOAD && in_valid;
  assign acc           = state_q == DRAIN && out_ready;
  assign k_last        = k_q == KW'(2 * NW - 1);
  assign m_last        = m_q == MW'(NW - 1);
  assign in_ready      = state_q == LOAD;
  assign busy          = state_q != LOAD;
  assign core_valid_in = state_q == START && core_ready;
  assign out_valid     = state_q == DRAIN;
  assign out_last      = out_valid && m_last;
  assign core_plaintext = pt_q;
  assign core_key       = key_q;

  // Scatter the incoming word of every share into its interleaved shbus positions
  always_comb begin
    pt_d  = pt_q;
    key_d = key_q;
    for (int w = 0; w < NW; w++)
      for (int i = 0; i < d; i++)
        for (int j = 0; j < W; j++) begin
          if (ld && k_q == KW'(w)) pt_d[(W*w+j)*d+i] = in_data[W*i+j];
          if (ld && k_q == KW'(w + NW)) key_d[(W*w+j)*d+i] = in_data[W*i+j];
        end
  end

  // Gather word m of every share back out of the captured ciphertext; zero outside DRAIN
  always_comb begin
    out_data = '0;
    for (int w = 0; w < NW; w++)
      for (int i = 0; i < d; i++)
        for (int j = 0; j < W; j++)
          if (out_valid && m_q == MW'(w)) out_data[W*i+j] = buf_q[(W*w+j)*d+i];
  end

  // Sequencing: load beats, start the core once, wait for ciphertext, drain beats
  always_comb begin
    k_d   = ld ? (k_last ? '0 : k_q + KW'(1)) : k_q;
    m_d   = acc ? (m_last ? '0 : m_q + MW'(1)) : m_q;
    buf_d = (state_q == WAIT && core_cipher_valid) ? core_ciphertext : buf_q;
    state_d = state_q;
    case (state_q)
      LOAD:    state_d = (ld && k_last) ? START : LOAD;
      START:   state_d = core_ready ? WAIT : START;
      WAIT:    state_d = core_cipher_valid ? DRAIN : WAIT;
      default: state_d = (acc && m_last) ? LOAD : DRAIN;
    endcase
  end

  // State and data registers, all cleared by reset so a partial block is discarded
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= LOAD;
      k_q     <= '0;
      m_q     <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      buf_q   <= buf_d;
    end
  end
endmodule

// File: tb/tb_mskaes_serial_wrapper.sv
// tb_mskaes_serial_wrapper: randomized self-checking bench with a share-level reference model
module tb_mskaes_serial_wrapper;
  logic         clk = 0, nrst = 0, in_valid = 0, out_ready = 0, core_ready = 0, core_cipher_valid = 0;
  logic [63:0]  in_data = '0;
  logic [255:0] core_ciphertext = '0;
  logic         in_ready, out_valid, out_last, busy, core_valid_in;
  logic [63:0]  out_data;
  logic [255:0] core_plaintext, core_key;
  int           checks = 0, failures = 0;
  logic [31:0]  pt[2][4], key[2][4];
  logic [255:0] ct;

  mskaes_serial_wrapper #(.d(2), .W(32)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .core_valid_in(core_valid_in), .core_ready(core_ready),
    .core_cipher_valid(core_cipher_valid), .core_plaintext(core_plaintext),
    .core_key(core_key), .core_ciphertext(core_ciphertext)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] to_shbus(input logic [127:0] s0, input logic [127:0] s1);
    logic [255:0] r;
    for (int b = 0; b < 128; b++) begin
      r[b*2]   = s0[b];
      r[b*2+1] = s1[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] share_of(input logic [255:0] bus, input int i);
    logic [127:0] r;
    for (int b = 0; b < 128; b++) r[b] = bus[b*2+i];
    return r;
  endfunction

  function automatic logic [255:0] exp_pt();
    return to_shbus({pt[0][3], pt[0][2], pt[0][1], pt[0][0]}, {pt[1][3], pt[1][2], pt[1][1], pt[1][0]});
  endfunction

  function automatic logic [255:0] exp_key();
    return to_shbus({key[0][3], key[0][2], key[0][1], key[0][0]}, {key[1][3], key[1][2], key[1][1], key[1][0]});
  endfunction

  task automatic randomize_block();
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 4; w++) begin
        pt[i][w]  = $urandom;
        key[i][w] = $urandom;
      end
    for (int w = 0; w < 8; w++) ct[w*32 +: 32] = $urandom;
  endtask

  task automatic load_block(input int beats, input logic gaps);
    for (int k = 0; k < beats; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 0;
        in_data  = $urandom;
      end
      @(negedge clk);
      in_valid = 1;
      if (k < 4) in_data = {pt[1][k], pt[0][k]};
      else in_data = {key[1][k-4], key[0][k-4]};
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_in_ready beat %0d: got %b want 1", k, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic start_and_core(input int stall, input int lat);
    core_ready = 0;
    #1;
    checks++;
    if (core_plaintext !== exp_pt() || core_key !== exp_key()) begin
      failures++;
      $display("FAIL core_bus: pt got %h want %h key got %h want %h", core_plaintext, exp_pt(), core_key, exp_key());
    end
    for (int s = 0; s < stall; s++) begin
      checks++;
      if (core_valid_in !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL start_stall cycle %0d: valid_in=%b busy=%b in_ready=%b want 0 1 0", s, core_valid_in, busy, in_ready);
      end
      @(negedge clk);
      #1;
    end
    core_ready = 1;
    #1;
    checks++;
    if (core_valid_in !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse: got %b want 1", core_valid_in);
    end
    @(negedge clk);
    #1;
    checks++;
    if (core_valid_in !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL pulse_end: valid_in=%b busy=%b out_valid=%b want 0 1 0", core_valid_in, busy, out_valid);
    end
    repeat (lat - 2) @(negedge clk);
    core_ciphertext   = ct;
    core_cipher_valid = 1;
    @(negedge clk);
    core_cipher_valid = 0;
    core_ciphertext   = {8{$urandom}};
    core_ready        = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input int mode, input int nb);
    logic [127:0] s0, s1;
    logic [63:0]  exp_d, pd;
    logic         pv, pr, pl;
    int           m, cyc;
    s0 = share_of(ct, 0);
    s1 = share_of(ct, 1);
    m = 0; cyc = 0; pv = 0; pr = 0; pd = '0; pl = 0;
    while (m < nb && cyc < 60) begin
      @(negedge clk);
      out_ready = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      exp_d = {s1[32*m +: 32], s0[32*m +: 32]};
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== (m == 3)) begin
        failures++;
        $display("FAIL drain_beat %0d: valid=%b data=%h last=%b want 1 %h %b", m, out_valid, out_data, out_last, exp_d, m == 3);
      end
      if (pv && !pr) begin
        checks++;
        if (out_data !== pd || out_last !== pl) begin
          failures++;
          $display("FAIL stall_stable beat %0d: data=%h last=%b want %h %b", m, out_data, out_last, pd, pl);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      if (out_valid === 1'b1 && out_ready) m++;
      cyc++;
    end
    checks++;
    if (m < nb) begin
      failures++;
      $display("FAIL drain_timeout: got %0d beats want %0d", m, nb);
    end
    if (nb == 4) begin
      @(negedge clk);
      out_ready = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL after_drain: valid=%b last=%b data=%h in_ready=%b busy=%b want 0 0 0 1 0", out_valid, out_last, out_data, in_ready, busy);
      end
    end
  endtask

  task automatic full_block(input logic gaps, input int stall, input int lat, input int mode);
    load_block(8, gaps);
    start_and_core(stall, lat);
    drain(mode, 4);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || core_valid_in !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: in_ready=%b busy=%b out_valid=%b valid_in=%b last=%b want 1 0 0 0 0", in_ready, busy, out_valid, core_valid_in, out_last);
    end
    checks++;
    if (core_plaintext !== '0 || core_key !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_data: pt=%h key=%h out=%h want 0", core_plaintext, core_key, out_data);
    end
    repeat (2) @(negedge clk);
    nrst = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_load_start();
    randomize_block();
    for (int w = 0; w < 4; w++) begin
      pt[0][w] = 32'h1000_0000 + w;
      pt[1][w] = 32'h0;
    end
    core_ready = 1;
    load_block(8, 0);
    checks++;
    if (share_of(core_plaintext, 0) !== {pt[0][3], pt[0][2], pt[0][1], pt[0][0]}) begin
      failures++;
      $display("FAIL pt_share0: got %h want %h", share_of(core_plaintext, 0), {pt[0][3], pt[0][2], pt[0][1], pt[0][0]});
    end
    start_and_core(0, 10);
    drain(0, 4);
  endtask

  task automatic test_start_stall();
    randomize_block();
    full_block(0, 5, 10, 0);
  endtask

  task automatic test_spurious();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      core_cipher_valid = 1;
      core_ciphertext   = {8{$urandom}};
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== '0) begin
        failures++;
        $display("FAIL spurious_cv %0d: out_valid=%b in_ready=%b busy=%b data=%h want 0 1 0 0", c, out_valid, in_ready, busy, out_data);
      end
    end
    @(negedge clk);
    core_cipher_valid = 0;
    randomize_block();
    full_block(1, 1, 6, 1);
  endtask

  task automatic test_reset_drain();
    randomize_block();
    load_block(8, 0);
    start_and_core(0, 4);
    drain(0, 2);
    @(negedge clk);
    out_ready = 0;
    nrst = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || core_valid_in !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_drain: valid=%b last=%b valid_in=%b busy=%b in_ready=%b want 0 0 0 0 1", out_valid, out_last, core_valid_in, busy, in_ready);
    end
    @(negedge clk);
    nrst = 1;
    randomize_block();
    full_block(0, 2, 8, 0);
  endtask

  task automatic test_reset_load();
    randomize_block();
    load_block(3, 0);
    nrst = 0;
    @(negedge clk);
    nrst = 1;
    #1;
    checks++;
    if (core_plaintext !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_load: pt=%h in_ready=%b want 0 1", core_plaintext, in_ready);
    end
    randomize_block();
    full_block(1, 0, 5, 1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      randomize_block();
      full_block(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(3, 15), 1);
    end
  endtask

  initial begin
    test_reset();
    test_load_start();
    test_start_stall();
    test_spurious();
    test_reset_drain();
    test_reset_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mskaes_serial_wrapper.md
MSKAES_SERIAL_WRAPPER -- requirements
Module: mskaes_serial_wrapper

Interface
REQ-001 The module SHALL have parameter d, default 2, meaning the number of shares.
REQ-002 The module SHALL have parameter W, default 32, meaning bits per share per beat; W SHALL divide 128, with NW = 128/W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 nrst  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  wrapper accepts an input beat.
REQ-007 in_data  input  W*d  input beat; share i occupies bits [W*i +: W].
REQ-008 out_valid  output  1  ciphertext beat valid.
REQ-009 out_ready  input  1  downstream accepts a beat.
REQ-010 out_data  output  W*d  ciphertext beat, same layout as in_data.
REQ-011 out_last  output  1  high on the final (NW-th) ciphertext beat.
REQ-012 busy  output  1  high in any state other than LOAD.
REQ-013 core_valid_in  output  1  start pulse to the masked AES core.
REQ-014 core_ready  input  1  core can accept a new block.
REQ-015 core_cipher_valid  input  1  core ciphertext valid.
REQ-016 core_plaintext, core_key  output  128*d  shbus layout: bit b of share i at index b*d+i.
REQ-017 core_ciphertext  input  128*d  shbus layout.

Function
REQ-018 FSM states SHALL be LOAD, START, WAIT and DRAIN; the state SHALL reset to LOAD.
REQ-019 A beat SHALL transfer on a rising edge when in_valid and in_ready are both high; in_ready SHALL be 1 exactly in LOAD.
REQ-020 In LOAD, the beat counter k (0..2*NW-1) SHALL select the destination: k<NW writes plaintext word k (bits [W*k +: W] of every share), and k>=NW writes key word k-NW.
REQ-021 Word-to-shbus conversion SHALL be registered: beat bit j of share i SHALL go to core bus index (W*word+j)*d+i.
REQ-022 On the transfer with k=2*NW-1, k SHALL clear and the state SHALL go to START.
REQ-023 In START, core_valid_in SHALL equal core_ready (combinational); when core_ready=1 the state SHALL go to WAIT after that cycle, giving an exactly one-cycle start pulse.
REQ-024 core_valid_in SHALL be 0 in every other state.
REQ-025 core_plaintext and core_key SHALL stay stable from entry to START until the next LOAD transfer.
REQ-026 In WAIT, on core_cipher_valid=1 the wrapper SHALL capture core_ciphertext into the output buffer and go to DRAIN.
REQ-027 core_cipher_valid SHALL be ignored in LOAD, START and DRAIN.
REQ-028 In DRAIN, out_valid SHALL be 1 and out_data SHALL present word m (0..NW-1) of each share, de-interleaved from the buffer: share i bit j comes from buffer index (W*m+j)*d+i.
REQ-029 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-030 On an accepted beat m SHALL increment; on the accepted beat with m=NW-1 (out_last=1), m SHALL clear and the state SHALL return to LOAD.
REQ-031 out_valid, out_last and out_data SHALL be 0 outside DRAIN.
REQ-032 Total latency SHALL be 2*NW input beats + 1 START cycle minimum + core latency + 1 capture cycle before the first output beat.
REQ-033 For W=128, NW=1: plaintext takes one beat, key one beat, and out_last SHALL be 1 on the only output beat.

Reset
REQ-034 Asserting nrst low at any time, including mid-load, WAIT or DRAIN, SHALL immediately force LOAD, clear k and m, and drive out_valid=0, out_last=0, core_valid_in=0 and busy=0.
REQ-035 A partially loaded block SHALL be discarded on reset.
REQ-036 Data registers SHALL reset to 0.
REQ-037 Transfers SHALL be ignored while nrst=0.
REQ-038 After reset deasserts, in_ready SHALL be 1.

Verification (d=2, W=32, NW=4)
REQ-039 Reset -> in_ready=1, busy=0, out_valid=0, core_valid_in=0.
REQ-040 8 beats, share0 word k = 32'h1000_0000+k, share1 = 0 -> core_plaintext bit b*2 equals share0 plaintext bit b; core_valid_in is high for exactly 1 cycle with core_ready=1.
REQ-041 core_ready held 0 for 5 cycles in START -> core_valid_in stays 0 and the state holds START; when core_ready rises, a 1-cycle pulse is emitted.
REQ-042 Core model returns ciphertext after 10 cycles, with out_ready toggling 1,0,1,0 -> 4 beats delivered in order with data stable during stalls, out_last on beat 3, then in_ready=1.
REQ-043 Spurious core_cipher_valid during LOAD -> no state change and no output.
REQ-044 nrst pulsed low during DRAIN after beat 1 -> out_valid=0 at once, LOAD with k=0, and a subsequent full block processes correctly.
